// File: rtl/fmc_dvidp_dvi_out.sv
// DVI transmit raster generator and pixel formatter with SOF-based stream alignment.
// Optional colour-bar fill when DVI_OUT_TEST_PATTERN_EN is defined (zero fill otherwise).
module fmc_dvidp_dvi_out #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       pix_sof,
  input  logic [7:0] pix_red,
  input  logic [7:0] pix_green,
  input  logic [7:0] pix_blue,
  output logic       de_o,
  output logic       vsync_o,
  output logic       hsync_o,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       frame_start,
  output logic       underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  typedef enum logic {
    ST_ALIGN,
    ST_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  logic        r_s1_de, r_s1_hs, r_s1_vs;
  logic [23:0] r_s1_rgb;
  logic        r_s2_de, r_s2_hs, r_s2_vs;
  logic [23:0] r_s2_rgb;

  int unsigned w_h_u, w_v_u;
  logic        w_h_last, w_v_last;
  logic        w_active, w_origin, w_hs_on, w_vs_on;
  logic        w_ready, w_capture, w_underflow;
  logic [23:0] w_fill, w_rgb;

  always_comb begin
    w_h_u    = 32'(r_h_cnt);
    w_v_u    = 32'(r_v_cnt);
    w_h_last = (w_h_u == H_TOTAL - 1);
    w_v_last = (w_v_u == V_TOTAL - 1);
    w_active = (w_h_u < H_ACTIVE) && (w_v_u < V_ACTIVE);
    w_origin = (w_h_u == 0) && (w_v_u == 0);
    w_hs_on  = (w_h_u >= HS_BEG) && (w_h_u < HS_END);
    w_vs_on  = (w_v_u >= VS_BEG) && (w_v_u < VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (ce) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

`ifdef DVI_OUT_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  logic [2:0] w_bar;

  always_comb begin
    w_bar = (w_h_u / BAR_W > 7) ? 3'd7 : 3'(w_h_u / BAR_W);
    case (w_bar)
      3'd0:    w_fill = 24'hFFFFFF;
      3'd1:    w_fill = 24'hFFFF00;
      3'd2:    w_fill = 24'h00FFFF;
      3'd3:    w_fill = 24'h00FF00;
      3'd4:    w_fill = 24'hFF00FF;
      3'd5:    w_fill = 24'hFF0000;
      3'd6:    w_fill = 24'h0000FF;
      default: w_fill = 24'h000000;
    endcase
  end
`else
  always_comb begin
    w_fill = '0;
  end
`endif

  // In ALIGN a SOF beat only passes at the raster origin; in RUN the frame
  // position and the SOF flag must agree or the stream drops back to ALIGN.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_capture   = 1'b0;
    w_underflow = 1'b0;
    case (r_state)
      ST_ALIGN: begin
        if (w_active && pix_valid) begin
          if (!pix_sof) begin
            w_ready = 1'b1;
          end else if (w_origin) begin
            w_ready     = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_active) begin
          w_ready = 1'b1;
          if (!pix_valid) begin
            w_underflow = 1'b1;
            w_state_nxt = ST_ALIGN;
          end else if (pix_sof != w_origin) begin
            w_state_nxt = ST_ALIGN;
          end else begin
            w_capture = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_ALIGN;
    endcase
  end

  always_comb begin
    w_rgb = '0;
    if (w_active) begin
      w_rgb = w_capture ? {pix_red, pix_green, pix_blue} : w_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ALIGN;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_de  <= 1'b0;
      r_s1_hs  <= ~HS_POL;
      r_s1_vs  <= ~VS_POL;
      r_s1_rgb <= '0;
      r_s2_de  <= 1'b0;
      r_s2_hs  <= ~HS_POL;
      r_s2_vs  <= ~VS_POL;
      r_s2_rgb <= '0;
    end else if (ce) begin
      r_s1_de  <= w_active;
      r_s1_hs  <= w_hs_on ~^ HS_POL;
      r_s1_vs  <= w_vs_on ~^ VS_POL;
      r_s1_rgb <= w_rgb;
      r_s2_de  <= r_s1_de;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_s2_rgb <= r_s1_rgb;
    end
  end

  // Combinational strobes are masked by rst_n so they read 0 while reset is held.
  assign pix_ready   = rst_n & ce & w_ready;
  assign frame_start = rst_n & ce & w_origin;
  assign underflow   = rst_n & ce & w_underflow;

  assign de_o    = r_s2_de;
  assign hsync_o = r_s2_hs;
  assign vsync_o = r_s2_vs;
  assign red_o   = r_s2_rgb[23:16];
  assign green_o = r_s2_rgb[15:8];
  assign blue_o  = r_s2_rgb[7:0];

endmodule

// File: tb/tb_fmc_dvidp_dvi_out.sv
// Randomised bench for fmc_dvidp_dvi_out on a 14x7 raster against a frame-level reference model.
module tb_fmc_dvidp_dvi_out;

  localparam int unsigned HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int unsigned VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int unsigned HT = HA + HFP + HSW + HBP;
  localparam int unsigned VT = VA + VFP + VSW + VBP;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned FPIX = HA * VA;
  localparam bit HPOL = 1'b1, VPOL = 1'b1;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } obs_t;

  typedef struct packed {
    logic        sof;
    logic [23:0] rgb;
  } beat_t;

  localparam obs_t RST = '{de: 1'b0, hs: ~HPOL, vs: ~VPOL, rgb: 24'h0};

  logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic       pix_valid = 1'b0, pix_sof = 1'b0;
  logic [7:0] pix_red = '0, pix_green = '0, pix_blue = '0;
  logic       pix_ready, de_o, vsync_o, hsync_o, frame_start, underflow;
  logic [7:0] red_o, green_o, blue_o;

  fmc_dvidp_dvi_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .de_o(de_o), .vsync_o(vsync_o), .hsync_o(hsync_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: frame position, alignment flag, last two raster outputs.
  beat_t       q[$];
  obs_t        hist[$];
  int unsigned cnt;
  bit          aligned;
  bit          m_ready, m_acc, m_fs, m_uf, m_active, m_show;
  obs_t        m_obs;
  bit          chk_seq = 1'b0;
  int          de_idx;
  int          n_hs, n_uf;

  function automatic logic [23:0] fill_of(input int unsigned h);
`ifdef DVI_OUT_TEST_PATTERN_EN
    logic [23:0] bars [8];
    int unsigned b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    b = h / (HA / 8);
    if (b > 7) b = 7;
    return bars[b];
`else
    return 24'h0 | 24'(h & 0);
`endif
  endfunction

  function automatic void model_reset();
    cnt = 0;
    aligned = 1'b0;
    hist.delete();
  endfunction

  function automatic void model_eval();
    int unsigned h, v;
    bit origin;
    h = cnt % HT;
    v = cnt / HT;
    origin   = (cnt == 0);
    m_active = (h < HA) && (v < VA);
    if (aligned) m_ready = ce && m_active;
    else         m_ready = ce && m_active && pix_valid && (!pix_sof || origin);
    m_acc  = m_ready && pix_valid;
    m_fs   = ce && origin;
    m_uf   = ce && aligned && m_active && !pix_valid;
    m_show = m_acc && (aligned ? (pix_sof == origin) : (pix_sof && origin));
    m_obs.de  = m_active;
    m_obs.hs  = ((h >= HA + HFP) && (h < HA + HFP + HSW)) ~^ HPOL;
    m_obs.vs  = ((v >= VA + VFP) && (v < VA + VFP + VSW)) ~^ VPOL;
    m_obs.rgb = !m_active ? 24'h0 : (m_show ? {pix_red, pix_green, pix_blue} : fill_of(h));
  endfunction

  function automatic void model_advance();
    if (m_acc) void'(q.pop_front());
    hist.push_back(m_obs);
    if (hist.size() > 2) void'(hist.pop_front());
    if (m_active) aligned = m_show;
    cnt = (cnt + 1) % FT;
  endfunction

  task automatic push_frame(input bit rnd, input int unsigned corrupt);
    for (int unsigned n = 0; n < FPIX; n++) begin
      beat_t b;
      b.sof = (n == 0);
      if (rnd) begin
        b.rgb = 24'($urandom);
        if (corrupt != 0 && $urandom_range(0, corrupt) == 0) b.sof = ~b.sof;
      end else begin
        b.rgb = {8'(n), 8'(n) ^ 8'h55, ~8'(n)};
      end
      q.push_back(b);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_de"}, 32'(de_o), 32'(RST.de));
    check({tag, "_hs"}, 32'(hsync_o), 32'(RST.hs));
    check({tag, "_vs"}, 32'(vsync_o), 32'(RST.vs));
    check({tag, "_rgb"}, 32'({red_o, green_o, blue_o}), 32'(RST.rgb));
    check({tag, "_ready"}, 32'(pix_ready), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_uf"}, 32'(underflow), 32'd0);
  endtask

  task automatic check_all();
    obs_t e;
    e = (hist.size() == 2) ? hist[0] : RST;
    check("pix_ready", 32'(pix_ready), 32'(m_ready));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("underflow", 32'(underflow), 32'(m_uf));
    check("de_o", 32'(de_o), 32'(e.de));
    check("hsync_o", 32'(hsync_o), 32'(e.hs));
    check("vsync_o", 32'(vsync_o), 32'(e.vs));
    check("rgb_o", 32'({red_o, green_o, blue_o}), 32'(e.rgb));
    if (chk_seq && de_o) begin
      check("seq_red", 32'(red_o), 32'(de_idx % FPIX));
      de_idx++;
    end
  endtask

  task automatic cycle(input bit en, input bit drop);
    @(negedge clk);
    ce = en;
    if (q.size() > 0 && !drop) begin
      pix_valid = 1'b1;
      pix_sof   = q[0].sof;
      {pix_red, pix_green, pix_blue} = q[0].rgb;
    end else begin
      pix_valid = 1'b0;
      pix_sof   = 1'($urandom);
      {pix_red, pix_green, pix_blue} = 24'($urandom);
    end
    #1;
    model_eval();
    check_all();
    if (pix_valid && pix_ready) n_hs++;
    if (underflow) n_uf++;
    @(posedge clk);
    if (en) model_advance();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    q.delete();
  endtask

  initial begin
    int unsigned drop_at;
    bit found;

    // Held reset with an offered SOF beat: everything must stay at reset values.
    ce = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset("rst");
    reset_dut();

    // Raster only, no stream.
    repeat (2 * FT) cycle(1'b1, 1'b0);

    // Continuous stream from reset; pixel n lands on de_o cycle n.
    reset_dut();
    repeat (3) push_frame(1'b0, 0);
    chk_seq = 1'b1; de_idx = 0; n_uf = 0;
    repeat (3 * FT) cycle(1'b1, 1'b0);
    chk_seq = 1'b0;
    check("seq_count", 32'(de_idx), 32'(3 * FPIX));
    check("seq_no_uf", 32'(n_uf), 32'd0);

    // One-cycle dropout mid-frame in the second frame.
    repeat (3) push_frame(1'b0, 0);
    drop_at = FT + $urandom_range(1, VA - 1) * HT + $urandom_range(0, HA - 1);
    n_uf = 0;
    for (int unsigned i = 0; i < 3 * FT; i++) cycle(1'b1, i == drop_at);
    check("drop_uf_count", 32'(n_uf), 32'd1);

    // Three non-SOF beats offered in ALIGN off-origin are drained.
    reset_dut();
    cycle(1'b1, 1'b0);
    repeat (3) q.push_back('{sof: 1'b0, rgb: 24'($urandom)});
    push_frame(1'b1, 0);
    n_hs = 0;
    repeat (3) cycle(1'b1, 1'b0);
    check("drain3", 32'(n_hs), 32'd3);
    repeat (2 * FT) cycle(1'b1, 1'b0);

    // ce toggling every cycle.
    reset_dut();
    repeat (2) push_frame(1'b0, 0);
    for (int unsigned i = 0; i < 4 * FT; i++) cycle(1'(i % 2), 1'b0);

    // Random ce, dropouts and corrupted SOF flags.
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      if (q.size() < 40) push_frame(1'b1, 40);
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    end

    // Reset asserted at line 2, pixel 3.
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      if (cnt == 2 * HT + 3) found = 1'b1;
      else cycle(1'b1, 1'b0);
    end
    check("midrst_reached", 32'(found), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    ce = 1'b0;
    pix_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    q.delete();
    repeat (2) push_frame(1'b0, 0);
    repeat (2 * FT) cycle(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
